// File: rtl/poly_note_player.sv
// Multi-voice note player: per-voice duration counters and phase accumulators, one shared
// frequency lookup and one shared quarter-wave sine lookup, time-multiplexed per sample.
module poly_note_player #(
    parameter int VOICES    = 3,
    parameter int MIX_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  beat,
    input  logic [VOICES-1:0]     load_new_note,
    input  logic [6*VOICES-1:0]   note_to_load,
    input  logic [6*VOICES-1:0]   duration_to_load,
    output logic [VOICES-1:0]     done_with_note,
    input  logic                  generate_next_sample,
    output logic [15:0]           sample_out,
    output logic                  new_sample_ready,
    output logic [5:0]            freq_addr,
    input  logic [19:0]           step_in,
    output logic [9:0]            sine_addr,
    input  logic [15:0]           sine_data
);

    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [2:0] {IDLE, FREQ, PHASE, ACC, OUT} state_t;

    state_t              state_reg, state_next;
    logic [VW-1:0]       voice_reg, voice_next;
    logic signed [18:0]  acc_reg, acc_next;
    logic [5:0]          freq_addr_reg;
    logic [9:0]          sine_addr_reg;
    logic                neg_reg;
    logic [15:0]         sample_reg;
    logic                ready_reg;

    logic [5:0]          note_reg  [VOICES];
    logic [5:0]          count_reg [VOICES];
    logic [21:0]         phase_reg [VOICES];
    logic [VOICES-1:0]   active;

    logic [5:0]          note_sel;
    logic [21:0]         phase_sel;
    logic                active_sel;
    logic                load_sel;
    logic [21:0]         phase_upd;
    logic [9:0]          fold_addr;
    logic                last_voice;
    logic signed [18:0]  sample_ext;
    logic signed [18:0]  contrib;
    logic signed [18:0]  shifted;
    logic [15:0]         sample_sat;

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            logic phase_step;
            assign phase_step = (state_reg == PHASE) && (voice_reg == VW'(gi)) && active[gi];
            assign active[gi] = (count_reg[gi] != 6'd0) && (note_reg[gi] != 6'd0);
            assign done_with_note[gi] = (count_reg[gi] == 6'd0);

            // A load takes priority over both the beat decrement and the phase update.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    note_reg[gi]  <= 6'd0;
                    count_reg[gi] <= 6'd0;
                    phase_reg[gi] <= 22'd0;
                end else if (load_new_note[gi]) begin
                    note_reg[gi]  <= note_to_load[6*gi +: 6];
                    count_reg[gi] <= duration_to_load[6*gi +: 6];
                    phase_reg[gi] <= 22'd0;
                end else begin
                    if (beat && play_enable && (count_reg[gi] != 6'd0))
                        count_reg[gi] <= count_reg[gi] - 6'd1;
                    if (phase_step)
                        phase_reg[gi] <= phase_upd;
                end
            end
        end
    endgenerate

    always_comb begin
        note_sel   = 6'd0;
        phase_sel  = 22'd0;
        active_sel = 1'b0;
        load_sel   = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
            if (voice_reg == VW'(v)) begin
                note_sel   = note_reg[v];
                phase_sel  = phase_reg[v];
                active_sel = active[v];
                load_sel   = load_new_note[v];
            end
        end
    end

    // Odd quadrants walk the quarter table backwards; the upper half is negated in ACC.
    assign phase_upd  = active_sel ? (phase_sel + {2'b00, step_in}) : phase_sel;
    assign fold_addr  = phase_upd[20] ? ~phase_upd[19:10] : phase_upd[19:10];
    assign last_voice = (voice_reg == VW'(VOICES - 1));
    assign sample_ext = {{3{sine_data[15]}}, sine_data};
    assign contrib    = neg_reg ? -sample_ext : sample_ext;

    always_comb begin
        state_next = state_reg;
        voice_next = voice_reg;
        acc_next   = acc_reg;
        case (state_reg)
            IDLE: begin
                if (generate_next_sample && play_enable) begin
                    acc_next   = 19'sd0;
                    voice_next = '0;
                    state_next = FREQ;
                end
            end
            FREQ:  state_next = PHASE;
            PHASE: state_next = ACC;
            ACC: begin
                if (active_sel)
                    acc_next = acc_reg + contrib;
                if (last_voice) begin
                    state_next = OUT;
                end else begin
                    voice_next = voice_reg + 1'b1;
                    state_next = FREQ;
                end
            end
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shifted = acc_next >>> MIX_SHIFT;
        if (shifted > 19'sd32767)
            sample_sat = 16'h7FFF;
        else if (shifted < -19'sd32768)
            sample_sat = 16'h8000;
        else
            sample_sat = shifted[15:0];
    end

    // The result is registered on leaving the last ACC so it is valid during OUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            voice_reg     <= '0;
            acc_reg       <= 19'sd0;
            freq_addr_reg <= 6'd0;
            sine_addr_reg <= 10'd0;
            neg_reg       <= 1'b0;
            sample_reg    <= 16'd0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            voice_reg <= voice_next;
            acc_reg   <= acc_next;
            ready_reg <= (state_reg == ACC) && last_voice;
            if (state_reg == FREQ)
                freq_addr_reg <= note_sel;
            if (state_reg == PHASE) begin
                sine_addr_reg <= fold_addr;
                neg_reg       <= ~load_sel & phase_upd[21];
            end
            if ((state_reg == ACC) && last_voice)
                sample_reg <= sample_sat;
        end
    end

    assign freq_addr        = (state_reg == FREQ) ? note_sel : freq_addr_reg;
    assign sine_addr        = (state_reg == PHASE) ? fold_addr : sine_addr_reg;
    assign sample_out       = sample_reg;
    assign new_sample_ready = ready_reg;

endmodule

// File: tb/tb_poly_note_player.sv
// Directed bench for poly_note_player: registered ROM models, hand-computed expectations,
// plus a second instance with MIX_SHIFT = 0 for saturation.
module tb_poly_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic        beat;
    logic [2:0]  load_new_note;
    logic [17:0] note_to_load;
    logic [17:0] duration_to_load;
    logic [2:0]  done_with_note;
    logic        generate_next_sample;
    logic [15:0] sample_out;
    logic        new_sample_ready;
    logic [5:0]  freq_addr;
    logic [19:0] step_in;
    logic [9:0]  sine_addr;
    logic [15:0] sine_data;

    logic [2:0]  load_s;
    logic [17:0] note_s;
    logic [17:0] dur_s;
    logic [2:0]  done_s;
    logic        gen_s;
    logic [15:0] out_s;
    logic        ready_s;
    logic [5:0]  freq_addr_s;
    logic [19:0] step_s;
    logic [9:0]  sine_addr_s;
    logic [15:0] sine_data_s;

    int checks = 0;
    int errors = 0;
    logic [9:0] sa0, sa1;
    int lat, pulses;

    always #5 clk = ~clk;

    poly_note_player #(.VOICES(3), .MIX_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
        .load_new_note(load_new_note), .note_to_load(note_to_load),
        .duration_to_load(duration_to_load), .done_with_note(done_with_note),
        .generate_next_sample(generate_next_sample), .sample_out(sample_out),
        .new_sample_ready(new_sample_ready), .freq_addr(freq_addr), .step_in(step_in),
        .sine_addr(sine_addr), .sine_data(sine_data)
    );

    poly_note_player #(.VOICES(3), .MIX_SHIFT(0)) dut_sat (
        .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
        .load_new_note(load_s), .note_to_load(note_s),
        .duration_to_load(dur_s), .done_with_note(done_s),
        .generate_next_sample(gen_s), .sample_out(out_s),
        .new_sample_ready(ready_s), .freq_addr(freq_addr_s), .step_in(step_s),
        .sine_addr(sine_addr_s), .sine_data(sine_data_s)
    );

    function automatic logic [19:0] step_of(input logic [5:0] n);
        case (n)
            6'd0:    step_of = 20'h00400;
            6'd5:    step_of = 20'h00400;
            6'd7:    step_of = 20'h3FFFF;
            default: step_of = 20'h00100;
        endcase
    endfunction

    // Synchronous ROMs: data valid one cycle after the address.
    always @(posedge clk) begin
        step_in   <= step_of(freq_addr);
        sine_data <= {3'b000, sine_addr, 3'b000};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic load_voice(input int v, input logic [5:0] n, input logic [5:0] d);
        @(negedge clk);
        load_new_note[v]        = 1'b1;
        note_to_load[6*v +: 6]     = n;
        duration_to_load[6*v +: 6] = d;
        @(negedge clk);
        load_new_note = 3'b000;
    endtask

    task automatic give_beat();
        @(negedge clk);
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
    endtask

    task automatic do_request(input bit ovr, input bit drop);
        lat = 0;
        pulses = 0;
        @(negedge clk);
        generate_next_sample = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) generate_next_sample = 1'b0;
            if (n == 2) begin
                sa0 = sine_addr;
                if (ovr) begin
                    load_new_note[0]      = 1'b1;
                    note_to_load[5:0]     = 6'd7;
                    duration_to_load[5:0] = 6'd60;
                end
                if (drop) play_enable = 1'b0;
            end
            if (n == 3) load_new_note = 3'b000;
            if (n == 5) sa1 = sine_addr;
            if (new_sample_ready) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
        if (drop) play_enable = 1'b1;
    endtask

    task automatic do_request_s(input logic [15:0] exp, input string tag);
        int got_ready;
        got_ready = 0;
        @(negedge clk);
        gen_s = 1'b1;
        @(negedge clk);
        gen_s = 1'b0;
        for (int n = 0; n < 30 && got_ready == 0; n++) begin
            @(negedge clk);
            if (ready_s) got_ready = 1;
        end
        check_val({tag, "_ready"}, got_ready, 1);
        check_val(tag, out_s, exp);
    endtask

    int   wk   [5] = '{1, 5, 9, 13, 17};
    logic [9:0]  wsa  [5] = '{10'd255, 10'd768, 10'd255, 10'd768, 10'd255};
    logic [15:0] wsmp [5] = '{16'h01FE, 16'h0600, 16'hFE02, 16'hFA00, 16'h01FE};

    initial begin
        int wi;
        reset = 1'b1;
        play_enable = 1'b0;
        beat = 1'b0;
        load_new_note = 3'b000;
        note_to_load = '0;
        duration_to_load = '0;
        generate_next_sample = 1'b0;
        load_s = 3'b000;
        note_s = '0;
        dur_s = '0;
        gen_s = 1'b0;
        step_s = 20'h00400;
        sine_data_s = 16'h7FFF;

        repeat (2) @(negedge clk);
        check_val("rst_sample", sample_out, 16'h0000);
        check_val("rst_ready", new_sample_ready, 1'b0);
        check_val("rst_done", done_with_note, 3'b111);
        check_val("rst_freq_addr", freq_addr, 6'd0);
        check_val("rst_sine_addr", sine_addr, 10'd0);
        reset = 1'b0;
        play_enable = 1'b1;

        // Single voice: note 5, duration 3, step 0x400 -> address 1, rom[1]=8 -> 2
        load_voice(0, 6'd5, 6'd3);
        check_val("load_done", done_with_note, 3'b110);
        do_request(1'b0, 1'b0);
        check_val("single_latency", lat, 10);
        check_val("single_pulses", pulses, 1);
        check_val("single_sine_addr", sa0, 10'd1);
        check_val("single_sample", sample_out, 16'h0002);

        // Asynchronous reset in the middle of a sequence
        @(negedge clk);
        generate_next_sample = 1'b1;
        repeat (4) begin
            @(negedge clk);
            generate_next_sample = 1'b0;
        end
        #1 reset = 1'b1;
        #1;
        check_val("async_rst_sample", sample_out, 16'h0000);
        check_val("async_rst_ready", new_sample_ready, 1'b0);
        check_val("async_rst_done", done_with_note, 3'b111);
        check_val("async_rst_freq", freq_addr, 6'd0);
        check_val("async_rst_sine", sine_addr, 10'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (new_sample_ready) pulses++;
        end
        check_val("async_rst_no_ready", pulses, 0);

        // Duration counting, gated by play_enable
        play_enable = 1'b0;
        load_voice(0, 6'd5, 6'd3);
        repeat (3) give_beat();
        check_val("beats_disabled_hold", done_with_note[0], 1'b0);
        play_enable = 1'b1;
        repeat (2) give_beat();
        check_val("beat2_not_done", done_with_note[0], 1'b0);
        give_beat();
        check_val("beat3_done", done_with_note[0], 1'b1);
        give_beat();
        check_val("beat4_saturate", done_with_note[0], 1'b1);

        // Load and beat on the same voice in the same cycle: load wins
        @(negedge clk);
        load_new_note[0] = 1'b1;
        note_to_load[5:0] = 6'd5;
        duration_to_load[5:0] = 6'd2;
        beat = 1'b1;
        @(negedge clk);
        load_new_note = 3'b000;
        beat = 1'b0;
        give_beat();
        check_val("load_beat_count1", done_with_note[0], 1'b0);
        give_beat();
        check_val("load_beat_count0", done_with_note[0], 1'b1);

        // Rest voice: voice 1 note 0 holds phase 0 and adds nothing
        load_voice(0, 6'd5, 6'd40);
        load_voice(1, 6'd0, 6'd10);
        check_val("rest_done", done_with_note, 3'b100);
        for (int k = 1; k <= 5; k++) begin
            do_request(1'b0, 1'b0);
            check_val($sformatf("rest%0d_v0_addr", k), sa0, k);
            check_val($sformatf("rest%0d_v1_addr", k), sa1, 10'd0);
            check_val($sformatf("rest%0d_sample", k), sample_out, 2 * k);
        end

        // Wrap and fold with step 0x3FFFF
        load_voice(0, 6'd7, 6'd60);
        wi = 0;
        for (int k = 1; k <= 17; k++) begin
            do_request(1'b0, 1'b0);
            if (wi < 5 && k == wk[wi]) begin
                check_val($sformatf("wrap%0d_addr", k), sa0, wsa[wi]);
                check_val($sformatf("wrap%0d_sample", k), sample_out, wsmp[wi]);
                wi++;
            end
        end

        // Load during PHASE(0) clears the phase; next request starts from 0
        do_request(1'b1, 1'b0);
        do_request(1'b0, 1'b0);
        check_val("override_addr", sa0, 10'd255);
        check_val("override_sample", sample_out, 16'h01FE);

        // play_enable dropped mid-sequence still completes
        do_request(1'b0, 1'b1);
        check_val("drop_enable_latency", lat, 10);

        // Requests while disabled are ignored
        play_enable = 1'b0;
        do_request(1'b0, 1'b0);
        check_val("disabled_no_ready", pulses, 0);
        play_enable = 1'b1;

        // Saturation on the MIX_SHIFT = 0 instance
        @(negedge clk);
        load_s = 3'b111;
        note_s = {6'd1, 6'd1, 6'd1};
        dur_s = {6'd63, 6'd63, 6'd63};
        @(negedge clk);
        load_s = 3'b000;
        step_s = 20'h00400;
        do_request_s(16'h7FFF, "sat_pos_q0");
        step_s = 20'hFFFFF;
        do_request_s(16'h7FFF, "sat_pos_q1");
        do_request_s(16'h8000, "sat_neg_q2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_note_player.md
# poly_note_player

Multi-voice successor to the single-voice note player. It holds `VOICES` independent notes, each with its own duration counter and phase accumulator. On each codec request it produces one mixed sample by time-multiplexing a single frequency-table lookup and a single quarter-wave sine lookup across all voices. It sits between the song/chord sequencer (which loads notes per voice) and the codec interface; the frequency ROM and sine ROM stay external and are wired by the parent.

## Interface
- `VOICES`, default 3: number of voices, 1..8.
- `MIX_SHIFT`, default 2: arithmetic right shift applied to the voice sum before saturation.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `play_enable` in 1: high = counters advance and sample requests are served.
- `beat` in 1: 1/48 s single-cycle tick.
- `load_new_note` in `VOICES`: per-voice load strobe.
- `note_to_load` in `6*VOICES`: note for voice v in bits [6v+5:6v]; 0 = rest.
- `duration_to_load` in `6*VOICES`: duration in beats for voice v in bits [6v+5:6v].
- `done_with_note` out `VOICES`: bit v high while voice v's counter is 0.
- `generate_next_sample` in 1: codec request pulse.
- `sample_out` out 16: signed mixed sample, registered.
- `new_sample_ready` out 1: one-cycle pulse when `sample_out` is updated.
- `freq_addr` out 6: frequency ROM address.
- `step_in` in 20: ROM step value, valid 1 cycle after `freq_addr`.
- `sine_addr` out 10: sine ROM address.
- `sine_data` in 16: signed quarter-wave sample, valid 1 cycle after `sine_addr`.

## Operation
- Per voice v, the block holds:
  - `note[v]` (6 b)
  - `count[v]` (6 b)
  - `phase[v]` (22 b)
- Loading:
  - `load_new_note[v]` latches `note[v]` and `count[v]` from the inputs and clears `phase[v]` to 0.
  - A load is accepted regardless of `play_enable`.
- Counting:
  - On `beat` with `play_enable` high, each `count[v]` not equal to 0 decrements.
  - Each counter saturates at 0.
  - If a load and a beat hit the same voice in the same cycle, the load wins.
- Voice v is active when `count[v] != 0` and `note[v] != 0`.
  - An inactive voice contributes 0 to the mix.
  - Its phase is held.
- Sequencer FSM states: IDLE, FREQ(v), PHASE(v), ACC(v), OUT.
  - IDLE: if `generate_next_sample` and `play_enable` are both high, clear the accumulator and go to FREQ(0). Otherwise the request is ignored; requests arriving outside IDLE are also ignored.
  - FREQ(v): drive `freq_addr = note[v]` (the note is sampled here) → PHASE(v).
  - PHASE(v): if active, `phase[v] += {2'b0, step_in}` with mod 2^22 wrap. Drive `sine_addr` from the updated phase. → ACC(v).
  - ACC(v): if active, add sign-extended `sine_data` (after folding, below) to the accumulator → FREQ(v+1), or OUT after the last voice.
  - OUT: `sample_out = sat16(acc >>> MIX_SHIFT)` and pulse `new_sample_ready` → IDLE.
- Quarter-wave folding:
  - Let q = phase[21:20] and i = phase[19:10].
  - `sine_addr` = i for q ∈ {0,2}, and ~i for q ∈ {1,3}.
  - The sample is negated (two's complement) for q ∈ {2,3}.
- Arithmetic:
  - Accumulator is 16+3 bits, signed.
  - The shift is arithmetic.
  - sat16 clamps to [−32768, 32767].

## Timing
- Reset values:
  - `sample_out` = 0, `new_sample_ready` = 0.
  - `done_with_note` = all ones; all counts are 0.
  - `freq_addr` = 0, `sine_addr` = 0.
  - Phases and notes are 0; FSM is in IDLE.
- Latency: a request seen in IDLE in cycle t produces `new_sample_ready` high in cycle t+3·VOICES+1 only, with `sample_out` valid from that cycle.
- `done_with_note` is combinational from the counters: it goes high the cycle after the decrementing beat, and low the cycle after a load with nonzero duration.
- Dropping `play_enable` mid-sequence does not abort the sequence; the sample still completes.
- A load of voice v during that voice's PHASE(v) overrides the phase update (phase = 0).
- Reset asserted mid-sequence: state returns to IDLE immediately and no `new_sample_ready` is issued.

## Test plan
- Reset: assert `reset` asynchronously mid-sequence → outputs take their reset values with no clock edge, `done_with_note` = 3'b111, and no ready pulse.
- Single voice: load voice 0 with note 5, duration 3, `step_in` model returns 0x00400; issue 1 request → ready at t+10, `sine_addr` = 1, `sample_out` = rom[1]>>>2.
- Duration: with note 5 / duration 3 loaded, give 3 beats with `play_enable` → done[0] rises after the 3rd beat; a 4th beat leaves count at 0. The same beats with `play_enable` low leave count at 3.
- Rest and inactive: voice 1 with note 0, duration 10 → contributes 0 and its phase stays 0 across 5 requests.
- Saturation: `MIX_SHIFT` = 0 with 3 voices all forced to `sine_data` = 0x7FFF, q = 0 → `sample_out` = 0x7FFF. With q = 2 on all voices → 0x8000.
- Wrap and fold: step 0x3FFFF over repeated requests → phase wraps past 2^22, quadrant 1 addresses `~i`, and quadrant 3 gives a negated sample. Simultaneous load and beat on the same voice → the count equals the loaded duration.
